pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage pipeline registers (F/D/E/M/W stall+flush flops).
//   Resolves load-use interlock, taken-branch redirect, multi-cycle E-stage ops, and data-memory wait states.
//   Also runs a post-reset drain so every stage holds a bubble before fetch starts.
//   Sits beside the datapath; its outputs drive the stall/flush pins of every pipeline register.
// PARAMETERS
//   REG_ADDR_W    5   register-index width
//   DRAIN_CYCLES  4   cycles spent in DRAIN after reset release (>=1)
//   MEM_TIMEOUT   64  max MEM_WAIT cycles before forced release (>=2)
//   PERF_W        32  stall-cycle counter width
// PORTS
//   clk           in   1           rising-edge clock
//   reset         in   1           asynchronous, active-low reset
//   rs1D, rs2D    in   REG_ADDR_W  source regs of instr in D
//   rdE           in   REG_ADDR_W  dest reg of instr in E
//   memReadE      in   1           instr in E is a load
//   branchTakenE  in   1           E resolves a redirect (taken branch/jump)
//   mcStartE      in   1           multi-cycle op (mul/div) starts in E; 1-cycle pulse
//   mcDoneE       in   1           multi-cycle unit result valid; 1-cycle pulse
//   memReqM       in   1           M stage has an outstanding data access (level)
//   memReadyM     in   1           data memory completes access this cycle
//   stallF/D/E/M  out  1 each      hold corresponding pipeline register
//   flushD/E/M/W  out  1 each      load bubble into corresponding pipeline register
//   memErr        out  1           sticky: a memory access hit MEM_TIMEOUT
//   stallCount    out  PERF_W      cycles with stallF=1 outside DRAIN; saturating
// BEHAVIOUR
//   States: DRAIN, RUN, MC_WAIT, MEM_WAIT. State, drain/timeout counters, mcDoneSeen, memErr, stallCount are async-reset.
//   reset low: state=DRAIN, counters=0, memErr=0, stallCount=0; outputs stallF=1, flushD/E/M/W=1, others 0.
//   DRAIN: same outputs as reset; after DRAIN_CYCLES cycles -> RUN. All inputs ignored.
//   Output priority (highest first), evaluated combinationally each cycle:
//     1 MEM stall  (state MEM_WAIT, or RUN/MC_WAIT with memReqM&~memReadyM): stallF/D/E/M=1, flushW=1.
//     2 MC stall   (state MC_WAIT, mcDoneE=0, mcDoneSeen=0): stallF/D/E=1, flushM=1.
//     3 redirect   (branchTakenE & no stall above): flushD=1, flushE=1. Suppressed while E stalled; E re-presents it.
//     4 load-use   (memReadE & rdE!=0 & (rdE==rs1D|rdE==rs2D) & ~branchTakenE): stallF/D=1, flushE=1.
//   Transitions:
//     RUN: memReqM&~memReadyM -> MEM_WAIT (takes precedence); else mcStartE -> MC_WAIT.
//     MC_WAIT: mcDoneE or mcDoneSeen (and no mem stall) -> RUN; outputs unstalled that same cycle.
//       mem stall during MC_WAIT -> MEM_WAIT with return-to-MC flag; mcDoneE arriving while in MEM_WAIT sets mcDoneSeen.
//     MEM_WAIT: memReadyM -> RUN (or MC_WAIT if return flag), unstalled that cycle; timeout counter clears.
//       timeout counter reaches MEM_TIMEOUT-1 -> set memErr, release as if memReadyM.
//   mcDoneSeen clears on exit from MC_WAIT. mcStartE while already in MC_WAIT/MEM_WAIT is ignored.
//   stallCount +1 per cycle with stallF=1 in RUN/MC_WAIT/MEM_WAIT; holds at 2^PERF_W-1.
//   reset asserted mid-operation: immediate return to DRAIN, all state cleared; no partial stall survives.
//   Outputs depend only on state and current inputs; no added latency between hazard and stall.
// STRUCTURE
//   Package pipeline_ctrl_pkg: state_t enum {DRAIN,RUN,MC_WAIT,MEM_WAIT}, ctrl_out_t struct of stall/flush bits.
//   Sub-module load_use_detect: combinational comparator for priority-4 term; everything else inline.
// TESTING
//   reset low 3 cycles, release -> 4 cycles stallF=1, flushD..W=1, then state RUN, all outputs 0.
//   memReadE=1, rdE=5, rs2D=5 -> stallF=stallD=flushE=1 one cycle; rdE=0,rs1D=0 -> no stall.
//   mcStartE at cycle 10, mcDoneE at cycle 16 -> stallF/D/E,flushM=1 cycles 11-15, clear at 16; stallCount=5.
//   MC_WAIT, memReqM=1 memReadyM=0 cycles 12-14, mcDoneE at 13 -> mem stall to 14, RUN at 15 via mcDoneSeen.
//   memReqM=1, memReadyM never -> release after MEM_TIMEOUT cycles, memErr=1 stays until reset.
//   branchTakenE with load-use same cycle -> flushD=flushE=1, stallF=0; reset mid-MEM_WAIT -> DRAIN outputs.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the stall/flush bundle.
// Pure declarations; no latency or flow control of its own.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAIN    = 2'd0,
        RUN      = 2'd1,
        MC_WAIT  = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_NONE = '{
        stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0, flush_w: 1'b0
    };

    // Fetch frozen while every downstream register loads a bubble.
    localparam ctrl_out_t CTRL_DRAIN = '{
        stall_f: 1'b1, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b1, flush_w: 1'b1
    };

    localparam ctrl_out_t CTRL_MEM = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
        flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b0, flush_w: 1'b1
    };

    localparam ctrl_out_t CTRL_MC = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b1, flush_w: 1'b0
    };

    localparam ctrl_out_t CTRL_REDIR = '{
        stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b0, flush_w: 1'b0
    };

    localparam ctrl_out_t CTRL_LOAD_USE = '{
        stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0, stall_m: 1'b0,
        flush_d: 1'b0, flush_e: 1'b1, flush_m: 1'b0, flush_w: 1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Load-use interlock comparator: a load in E writing a register that the instruction in D reads.
// Purely combinational, zero latency; no flow control.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  mem_read_e,
    output logic                  hazard
);

    logic rd_nonzero;
    logic src_match;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        rd_nonzero = (rd_e != '0);
        src_match  = (rd_e == rs1_d) || (rd_e == rs2_d);
        hazard     = mem_read_e && rd_nonzero && src_match;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drain, memory wait, multi-cycle op, redirect, load-use.
// Outputs are combinational from state and current inputs (zero latency); memory and MC stalls backpressure F..E/M.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 64,
    parameter int PERF_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdE,
    input  logic                  memReadE,
    input  logic                  branchTakenE,
    input  logic                  mcStartE,
    input  logic                  mcDoneE,
    input  logic                  memReqM,
    input  logic                  memReadyM,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  stallM,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushM,
    output logic                  flushW,
    output logic                  memErr,
    output logic [PERF_W-1:0]     stallCount
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TMO_W   = $clog2(MEM_TIMEOUT);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               mc_ret_q, mc_ret_d;
    logic               mc_done_seen_q, mc_done_seen_d;
    logic               mem_err_q, mem_err_d;
    logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic      lu_hazard;
    logic      mem_pending;
    logic      tmo_hit;
    logic      mem_release;
    logic      mc_done;
    logic      mem_stall;
    logic      mc_stall;
    ctrl_out_t ctrl;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .rs1_d      (rs1D),
        .rs2_d      (rs2D),
        .rd_e       (rdE),
        .mem_read_e (memReadE),
        .hazard     (lu_hazard)
    );

    always_comb begin
        mem_pending = memReqM && !memReadyM;
        tmo_hit     = (tmo_cnt_q == TMO_LAST);
        mem_release = memReadyM || tmo_hit;
        mc_done     = mcDoneE || mc_done_seen_q;

        if (state_q == MEM_WAIT) begin
            mem_stall = !mem_release;
        end else begin
            mem_stall = ((state_q == RUN) || (state_q == MC_WAIT)) && mem_pending;
        end

        // A memory release that hands back to an unfinished MC op must keep E held.
        mc_stall = !mc_done &&
                   ((state_q == MC_WAIT) || ((state_q == MEM_WAIT) && mc_ret_q));

        ctrl = CTRL_NONE;
        if (state_q == DRAIN) begin
            ctrl = CTRL_DRAIN;
        end else if (mem_stall) begin
            ctrl = CTRL_MEM;
        end else if (mc_stall) begin
            ctrl = CTRL_MC;
        end else if (branchTakenE) begin
            ctrl = CTRL_REDIR;
        end else if (lu_hazard) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        mc_ret_d       = mc_ret_q;
        mc_done_seen_d = mc_done_seen_q;
        mem_err_d      = mem_err_q;
        stall_cnt_d    = stall_cnt_q;

        case (state_q)
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = RUN;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            RUN: begin
                if (mem_pending) begin
                    state_d   = MEM_WAIT;
                    mc_ret_d  = 1'b0;
                    tmo_cnt_d = '0;
                end else if (mcStartE) begin
                    state_d        = MC_WAIT;
                    mc_done_seen_d = 1'b0;
                end
            end
            MC_WAIT: begin
                if (mem_pending) begin
                    state_d        = MEM_WAIT;
                    mc_ret_d       = 1'b1;
                    tmo_cnt_d      = '0;
                    mc_done_seen_d = mc_done;
                end else if (mc_done) begin
                    state_d        = RUN;
                    mc_done_seen_d = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (mc_ret_q && mcDoneE) begin
                    mc_done_seen_d = 1'b1;
                end
                if (mem_release) begin
                    tmo_cnt_d = '0;
                    mc_ret_d  = 1'b0;
                    if (!memReadyM) begin
                        mem_err_d = 1'b1;
                    end
                    // Completion already observed means the MC op needs no further wait.
                    if (mc_ret_q && !mc_done) begin
                        state_d = MC_WAIT;
                    end else begin
                        state_d        = RUN;
                        mc_done_seen_d = 1'b0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = DRAIN;
            end
        endcase

        if ((state_q != DRAIN) && ctrl.stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= DRAIN;
            drain_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            mc_ret_q       <= 1'b0;
            mc_done_seen_q <= 1'b0;
            mem_err_q      <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            mc_ret_q       <= mc_ret_d;
            mc_done_seen_q <= mc_done_seen_d;
            mem_err_q      <= mem_err_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign stallF     = ctrl.stall_f;
    assign stallD     = ctrl.stall_d;
    assign stallE     = ctrl.stall_e;
    assign stallM     = ctrl.stall_m;
    assign flushD     = ctrl.flush_d;
    assign flushE     = ctrl.flush_e;
    assign flushM     = ctrl.flush_m;
    assign flushW     = ctrl.flush_w;
    assign memErr     = mem_err_q;
    assign stallCount = stall_cnt_q;

endmodule
